// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply (radix-2 Booth) / restoring divide with HI/LO result registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;
    typedef enum logic [1:0] {OP_MULT, OP_DIV, OP_DZ} op_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     booth_a_ext, booth_m_ext, booth_sum;
    logic [WIDTH:0]     div_shifted;
    logic               div_ge;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        abs_a = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
        abs_b = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;

        // Add/sub one bit wider than HI so a -2^(WIDTH-1) multiplicand cannot overflow before the shift
        booth_a_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        booth_m_ext = {mcand_q[WIDTH-1], mcand_q};
        case (acc_q[1:0])
            2'b01:   booth_sum = booth_a_ext + booth_m_ext;
            2'b10:   booth_sum = booth_a_ext - booth_m_ext;
            default: booth_sum = booth_a_ext;
        endcase

        div_shifted = {rem_q, quo_q[WIDTH-1]};
        div_ge      = (div_shifted >= {1'b0, mcand_q});

        case (state_q)
            S_IDLE: begin
                if (mult_start) begin
                    state_d = S_MULT;
                    op_d    = OP_MULT;
                    cnt_d   = '0;
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
                    dz_d    = 1'b0;
                end else if (div_start) begin
                    cnt_d   = '0;
                    mcand_d = abs_b;
                    rem_d   = '0;
                    quo_d   = abs_a;
                    q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                    r_neg_d = a[WIDTH-1];
                    dz_d    = 1'b0;
                    if (b == '0) begin
                        op_d    = OP_DZ;
                        state_d = S_FINISH;
                    end else begin
                        op_d    = OP_DIV;
                        state_d = S_DIV;
                    end
                end
            end
            S_MULT: begin
                acc_d = {booth_sum, acc_q[WIDTH:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) state_d = S_FINISH;
            end
            S_DIV: begin
                rem_d = div_ge ? WIDTH'(div_shifted - {1'b0, mcand_q}) : div_shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_MULT: {hi_d, lo_d} = acc_q[2*WIDTH:1];
                    OP_DIV: begin
                        lo_d = q_neg_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
                        hi_d = r_neg_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                    end
                    default: dz_d = 1'b1;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - table, corner-sequence and random checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         mult_start = 1'b0;
    logic         div_start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_zero;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural HI/LO/div_zero as the instruction set defines them
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    typedef struct {
        int           op;   // 0 mult, 1 div, 2 both starts
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t tab[12];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model(input int op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op != 1) begin
            p = sx * sy;
            {m_hi, m_lo} = 64'(p);
            m_dz = 1'b0;
        end else if (y == '0) begin
            m_dz = 1'b1;
        end else begin
            m_lo = W'(sx / sy);
            m_hi = W'(sx % sy);
            m_dz = 1'b0;
        end
    endtask

    task automatic do_op(input int op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output int bcnt);
        a = x;
        b = y;
        mult_start = (op != 1);
        div_start  = (op != 0);
        @(posedge clk); #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic run_check(input string nm, input int op, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        int lat, bc, exp_lat;
        exp_lat = (op == 1 && y == '0) ? 1 : W + 1;
        do_op(op, x, y, lat, bc);
        check({nm, ".latency"}, 64'(lat), 64'(exp_lat));
        check({nm, ".busy_cycles"}, 64'(bc), 64'(exp_lat));
        check({nm, ".hi"}, 64'(hi), 64'(eh));
        check({nm, ".lo"}, 64'(lo), 64'(el));
        check({nm, ".div_zero"}, 64'(div_zero), 64'(edz));
        @(posedge clk); #1;
        check({nm, ".done_one_cycle"}, 64'(done), 64'(0));
    endtask

    initial begin
        int dcnt;
        logic [W-1:0] cap_hi, cap_lo;
        logic [W-1:0] x, y;
        int op;

        tab[0]  = '{0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tab[1]  = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tab[2]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tab[3]  = '{1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tab[4]  = '{1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tab[5]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tab[6]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tab[7]  = '{1, 32'd5,        32'd0,        32'h00000000, 32'h00000001, 1'b1};
        tab[8]  = '{0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tab[9]  = '{2, 32'd100,      32'd7,        32'h00000000, 32'd700,      1'b0};
        tab[10] = '{1, 32'd7,        32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tab[11] = '{1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

        #2;
        check("reset.hi", 64'(hi), 64'(0));
        check("reset.lo", 64'(lo), 64'(0));
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.div_zero", 64'(div_zero), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            model(tab[i].op, tab[i].a, tab[i].b);
            run_check($sformatf("vec%0d", i), tab[i].op, tab[i].a, tab[i].b, tab[i].hi, tab[i].lo, tab[i].dz);
        end

        // Start pulses and operand churn while busy: one result, from the captured 3 * 5
        a = 32'd3;
        b = 32'd5;
        mult_start = 1'b1;
        @(posedge clk); #1;
        mult_start = 1'b0;
        model(0, 32'd3, 32'd5);
        dcnt = 0;
        cap_hi = '1;
        cap_lo = '1;
        for (int c = 0; c < 80; c++) begin
            if (c < 20) begin
                a = $urandom;
                b = $urandom;
                mult_start = c[0];
                div_start  = ~c[0];
            end else begin
                mult_start = 1'b0;
                div_start  = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                cap_hi = hi;
                cap_lo = lo;
            end
        end
        check("busy_ignore.done_count", 64'(dcnt), 64'(1));
        check("busy_ignore.hi", 64'(cap_hi), 64'(m_hi));
        check("busy_ignore.lo", 64'(cap_lo), 64'(m_lo));

        // Asynchronous reset ten cycles into a divide
        a = 32'hFFFFFF9C;
        b = 32'd7;
        div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort.hi", 64'(hi), 64'(0));
        check("abort.lo", 64'(lo), 64'(0));
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.done", 64'(done), 64'(0));
        dcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abort.no_done", 64'(dcnt), 64'(0));
        check("abort.lo_after", 64'(lo), 64'(0));
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        model(0, 32'd7, 32'hFFFFFFFD);
        run_check("post_reset_mult", 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 1));
            x  = $urandom;
            case ($urandom_range(0, 5))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 20));
                2:       y = '0 - W'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) x = W'($urandom_range(0, 1000));
            model(op, x, y);
            run_check($sformatf("rnd%0d", i), op, x, y, m_hi, m_lo, m_dz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit serving the `mult`, `div`, `mfhi` and `mflo` instructions of the multicycle CPU. The control FSM issues a one-cycle start pulse with the register-file outputs A/B as operands, then holds in a wait state until `done`. Results live in internal HI/LO registers that feed the MemToReg mux for `mfhi`/`mflo`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces IDLE and clears all registers.
- `mult_start`  in  1  request signed multiply; sampled only in IDLE.
- `div_start`  in  1  request signed divide; sampled only in IDLE.
- `a`  in  WIDTH  operand: multiplicand / dividend (from register A).
- `b`  in  WIDTH  operand: multiplier / divisor (from register B).
- `hi`  out  WIDTH  HI: upper product half / remainder.
- `lo`  out  WIDTH  LO: lower product half / quotient.
- `busy`  out  1  operation in progress; start inputs ignored.
- `done`  out  1  one-cycle pulse; hi/lo are valid while it is high.
- `div_zero`  out  1  last accepted divide had b == 0.

## Operation
- States: IDLE, MULT, DIV, FINISH.
- IDLE: on an edge with `mult_start`=1, capture a/b into internal registers, clear the 6-bit iteration counter, go to MULT. If instead `div_start`=1, capture a/b and go to DIV. If b == 0 on that divide, go straight to FINISH. If both starts are high, multiply wins and the divide is dropped.
- MULT: radix-2 Booth, one step per cycle over a 2*WIDTH+1 bit accumulator with arithmetic right shift. After WIDTH steps, go to FINISH.
- DIV: restoring divide on magnitudes |a|, |b| (unsigned, WIDTH bits), one quotient bit per cycle. After WIDTH steps, go to FINISH.
- FINISH (one cycle), then IDLE:
  - Mult: {hi,lo} <= 2*WIDTH signed product.
  - Div: lo <= quotient, negated if sign(a) != sign(b); hi <= remainder, negated if a < 0. Quotient truncates toward zero.
  - Div by zero: hi/lo unchanged, `div_zero` <= 1.
  - `done` is asserted for exactly this cycle.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No exception is raised.
- `div_zero` is cleared by the next accepted start of either kind. Otherwise it holds.
- hi/lo hold their value between completions. Operand changes after acceptance have no effect.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, state IDLE.
- Let a start be accepted at edge k.
  - `busy` is high from edge k through edge k+WIDTH+1.
  - FINISH is active after edge k+WIDTH.
  - hi/lo update and `done` rises at edge k+WIDTH+1 (33 for WIDTH=32).
  - `busy` falls at that same edge.
- Div by zero: FINISH is active after edge k. `done` and `div_zero` are high after edge k+1, and `busy` falls at edge k+1.
- `done` and `busy` are registered outputs, never combinational from inputs.
- The earliest next accept is the edge where `done` is high, since IDLE is entered together with `done`.
- A start held high for several cycles is accepted exactly once per IDLE visit.
- `reset` low mid-operation aborts immediately and asynchronously. hi/lo go to 0, with no `done` and no partial result.
- Deassertion of `reset` is synchronised externally. The first accept can occur on the first edge after release.

## Test plan
- After reset: `mult_start` with a = 7, b = -3 (0xFFFFFFFD) -> `done` exactly 33 edges after accept; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high for 33 cycles.
- mult a = 0x80000000, b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000; mult 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0, lo = 1.
- div a = -7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, div_zero = 0; div 100 / 7 -> lo = 14, hi = 2; div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- div a = 5, b = 0 after a completed mult -> `done` 1 edge after the accept edge (2 cycles total), div_zero = 1, hi/lo retain the mult result; the next mult clears div_zero.
- Start pulses while busy, both starts together (mult wins), and a/b toggling mid-operation -> exactly one result, from the originally captured operands.
- `reset` low at cycle 10 of a divide -> hi = lo = 0, busy = 0 immediately, no `done`; after release, a new mult completes correctly in 33 cycles.
